// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first,
// WIDTH cycles per operation with a ready/busy/done FSM.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;
   logic             bit_s, bit_c, last;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      co_d    = co_q;
      ov_d    = ov_q;
      bit_s   = a_q[0] ^ b_q[0] ^ cy_q;
      bit_c   = (a_q[0] & b_q[0]) | (cy_q & (a_q[0] ^ b_q[0]));
      last    = (cnt_q == CW'(WIDTH - 1));
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = op_a;
               b_d     = sub ? ~op_b : op_b;
               cy_d    = sub;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {bit_s, res_q[WIDTH-1:1]};
            cy_d  = bit_c;
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (last) begin
               // cy_q is the carry into the MSB on this final slice
               state_d = DONE;
               sum_d   = {bit_s, res_q[WIDTH-1:1]};
               co_d    = bit_c;
               ov_d    = cy_q ^ bit_c;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
      end
   end

   assign ready     = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = co_q;
   assign overflow  = ov_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: WIDTH=8 scenarios plus a
// WIDTH=2 exhaustive sweep, results checked through scoreboard queues.
module tb_serial_add_sub;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       st8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       rdy8, bsy8, dn8, co8, ov8;
   logic [7:0] sum8;

   logic       st2 = 1'b0, sub2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       rdy2, bsy2, dn2, co2, ov2;
   logic [1:0] sum2;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q8[$];
   exp_t q2[$];
   logic dn8_p = 1'b0, dn2_p = 1'b0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub8),
      .op_a(a8), .op_b(b8), .ready(rdy8), .busy(bsy8), .done(dn8),
      .sum(sum8), .carry_out(co8), .overflow(ov8)
   );

   serial_add_sub #(.WIDTH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(st2), .sub(sub2),
      .op_a(a2), .op_b(b2), .ready(rdy2), .busy(bsy2), .done(dn2),
      .sum(sum2), .carry_out(co2), .overflow(ov2)
   );

   function automatic exp_t model(int w, bit s, int unsigned a, int unsigned b);
      exp_t        e;
      longint      mask, bb, t;
      bit          sa, sb, ss;
      mask = (64'd1 << w) - 1;
      bb   = s ? (~longint'(b) & mask) : longint'(b);
      t    = longint'(a) + bb + longint'(s);
      e.s  = 32'(t & mask);
      e.c  = 1'((t >> w) & 1);
      sa   = 1'((a >> (w - 1)) & 1);
      sb   = 1'((b >> (w - 1)) & 1);
      ss   = 1'((t >> (w - 1)) & 1);
      e.v  = s ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         n_vec++;
         assert ($onehot({rdy8, bsy8, dn8}) && $onehot({rdy2, bsy2, dn2}))
         else begin
            n_err++;
            $error("FAIL onehot observed=%b%b%b/%b%b%b expected=onehot",
                   rdy8, bsy8, dn8, rdy2, bsy2, dn2);
         end
         n_vec++;
         assert (!(dn8 && dn8_p) && !(dn2 && dn2_p)) else begin
            n_err++;
            $error("FAIL done_width observed=2cyc expected=1cyc");
         end
      end
      dn8_p = dn8 & rst_n;
      dn2_p = dn2 & rst_n;
   end

   // call at a negedge; returns just after the capture edge
   task automatic go8(bit s, logic [7:0] a, logic [7:0] b);
      chk("ready8", 32'(rdy8), 32'd1);
      sub8 = s; a8 = a; b8 = b; st8 = 1'b1;
      q8.push_back(model(8, s, a, b));
      @(posedge clk);
      #1 st8 = 1'b0;
   endtask

   task automatic wait8(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dn8 && n < 40);
      if (!dn8) chk("timeout8", 32'd0, 32'd1);
   endtask

   task automatic pop8(string tag);
      exp_t e;
      if (q8.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = q8.pop_front();
         chk({tag, "_sum"}, 32'(sum8), e.s);
         chk({tag, "_c"}, 32'(co8), 32'(e.c));
         chk({tag, "_v"}, 32'(ov8), 32'(e.v));
      end
   endtask

   task automatic op8(string tag, bit s, logic [7:0] a, logic [7:0] b);
      int n;
      go8(s, a, b);
      wait8(n);
      chk({tag, "_lat"}, 32'(n), 32'd9);
      pop8(tag);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(dn8), 32'd0);
   endtask

   task automatic quiet8(string tag, int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (dn8) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int   n;
      exp_t e;
      #1;
      chk("rst_ready", 32'(rdy8), 32'd1);
      chk("rst_busy", 32'(bsy8), 32'd0);
      chk("rst_done", 32'(dn8), 32'd0);
      chk("rst_out", {22'd0, co8, ov8, sum8}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      op8("add_0f_01", 1'b0, 8'h0F, 8'h01);
      op8("add_ff_01", 1'b0, 8'hFF, 8'h01);
      op8("add_7f_01", 1'b0, 8'h7F, 8'h01);
      op8("sub_05_07", 1'b1, 8'h05, 8'h07);
      op8("sub_80_01", 1'b1, 8'h80, 8'h01);
      op8("sub_33_33", 1'b1, 8'h33, 8'h33);

      // restart attempt and operand changes mid-run
      @(negedge clk);
      go8(1'b0, 8'h10, 8'h20);
      @(negedge clk);
      chk("hold_sum", 32'(sum8), 32'h00);
      st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a8 = 8'h55;
      wait8(n);
      chk("mid_lat", 32'(n + 2), 32'd9);
      pop8("mid");
      quiet8("mid_one_done", 14);

      // reset in the 4th RUN cycle
      go8(1'b0, 8'hAA, 8'h11);
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 32'(bsy8), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_state", {29'd0, rdy8, bsy8, dn8}, 32'b100);
      chk("arst_out", {22'd0, co8, ov8, sum8}, 32'd0);
      q8.delete();
      @(negedge clk);
      rst_n = 1'b1;
      quiet8("arst_no_done", 14);
      op8("post_rst", 1'b0, 8'h01, 8'h01);

      // start held high: new op every WIDTH+2 cycles
      sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h0A; st8 = 1'b1;
      q8.push_back(model(8, 0, 8'h3C, 8'h0A));
      q8.push_back(model(8, 0, 8'h3C, 8'h0A));
      wait8(n);
      pop8("b2b_1");
      wait8(n);
      chk("b2b_period", 32'(n), 32'd10);
      st8 = 1'b0;
      pop8("b2b_2");
      quiet8("b2b_stop", 14);

      // WIDTH=2 exhaustive sweep
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
               chk("ready2", 32'(rdy2), 32'd1);
               sub2 = 1'(s); a2 = 2'(a); b2 = 2'(b); st2 = 1'b1;
               q2.push_back(model(2, 1'(s), a, b));
               @(negedge clk);
               st2 = 1'b0;
               n = 0;
               while (!dn2 && n < 10) begin
                  @(negedge clk);
                  n++;
               end
               if (!dn2 || q2.size() == 0) begin
                  chk("timeout2", 32'd0, 32'd1);
               end else begin
                  e = q2.pop_front();
                  chk($sformatf("w2_%0d_%0d_%0d_lat", s, a, b), 32'(n), 32'd2);
                  chk($sformatf("w2_%0d_%0d_%0d", s, a, b),
                      {29'd0, co2, ov2, 1'b0} | {30'd0, sum2},
                      {29'd0, e.c, e.v, 1'b0} | e.s);
               end
               @(negedge clk);
            end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled on rising clk edge; accepted only when ready=1.
REQ-005 sub  input  1  mode, captured with start; 0 = A+B, 1 = A-B.
REQ-006 op_a  input  WIDTH  operand A, captured with start.
REQ-007 op_b  input  WIDTH  operand B, captured with start.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high only in RUN.
REQ-010 done  output  1  one-cycle completion pulse, high only in DONE.
REQ-011 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 carry_out  output  1  carry out of MSB; for subtract 1 = no borrow.
REQ-013 overflow  output  1  two's-complement signed overflow.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on a clk edge with start=1; op_a, op_b and sub captured into internal registers on that edge.
REQ-016 The block SHALL process one bit per cycle, LSB first, through a single full-adder slice and a carry flip-flop.
REQ-017 Carry flip-flop SHALL load sub at capture; B bit SHALL be inverted when captured sub=1.
REQ-018 A modulo-WIDTH bit counter SHALL start at 0 at capture; RUN -> DONE on the edge processing bit WIDTH-1.
REQ-019 Latency: done SHALL be high in the cycle after the WIDTH-th rising edge following the start-capture edge.
REQ-020 DONE -> IDLE unconditionally on the next edge; done SHALL never be high for two consecutive cycles.
REQ-021 sum, carry_out, overflow SHALL update only on the RUN -> DONE edge and hold until the next RUN -> DONE edge.
REQ-022 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-023 start while RUN or DONE SHALL be ignored, with no effect on the operation in flight.
REQ-024 Changes on op_a, op_b, sub after capture SHALL NOT affect the result.
REQ-025 Back-to-back: start held high continuously SHALL begin a new operation every WIDTH+2 cycles.
REQ-026 ready, busy, done SHALL be one-hot in every cycle out of reset.

Reset
REQ-027 rst_n=0 SHALL force immediately (without clock): state IDLE, ready=1, busy=0, done=0, sum=0, carry_out=0, overflow=0, counter=0, carry flip-flop=0.
REQ-028 Reset asserted during RUN or DONE SHALL abandon the operation; no done pulse SHALL follow release.
REQ-029 After rst_n rises, the first start SHALL be accepted on the first clk edge with start=1.

Verification (WIDTH=8 unless stated)
REQ-030 Add 0x0F+0x01 -> sum=0x10, carry_out=0, overflow=0; done exactly 1 cycle, 9 edges after capture.
REQ-031 Add 0xFF+0x01 -> 0x00, c=1, v=0. Add 0x7F+0x01 -> 0x80, c=0, v=1.
REQ-032 Sub 0x05-0x07 -> 0xFE, c=0, v=0. Sub 0x80-0x01 -> 0x7F, c=1, v=1.
REQ-033 Start 0x10+0x20, pulse start with 0xFF+0xFF mid-RUN and change op_a after capture -> result 0x30, c=0, v=0; one done pulse only.
REQ-034 rst_n low for one cycle at the 4th RUN cycle -> outputs at reset values asynchronously, no done; next start 0x01+0x01 -> 0x02.
REQ-035 WIDTH=2 exhaustive sweep: all 2x4x4=32 (sub, op_a, op_b) combinations -> sum, carry_out, overflow match the arithmetic reference model; ready/busy/done one-hot every cycle.
